// File: rtl/msx_mapper_bridge.sv
// MSX memory-mapper to PSRAM bridge.
// Decodes slot memory cycles and the four mapper ports, translates the Z80
// address through the segment registers and issues single-byte PSRAM
// transactions. Reads are answered from PSRAM (or from the segment registers
// for mapper port reads); a busy timeout aborts a stuck transfer.
module msx_mapper_bridge #(
   parameter int         SEG_BITS = 8,
   parameter logic [7:0] IO_BASE  = 8'hFC,
   parameter bit         READBACK = 1'b1,
   parameter int         TIMEOUT  = 255
) (
   input  logic                 clk_72m,
   input  logic                 bus_reset_n,
   input  logic [15:0]          bus_addr,
   input  logic [7:0]           bus_din,
   input  logic                 bus_mreq_n,
   input  logic                 bus_iorq_n,
   input  logic                 bus_rd_n,
   input  logic                 bus_wr_n,
   input  logic                 bus_sltsl_n,
   input  logic                 bus_rfsh_n,
   input  logic                 bus_clk_3m6,
   output logic [7:0]           bus_dout,
   output logic                 bus_drive,
   output logic                 psram_read,
   output logic                 psram_write,
   output logic [SEG_BITS+13:0] psram_addr,
   output logic [15:0]          psram_din,
   input  logic [15:0]          psram_dout,
   input  logic                 psram_busy,
   output logic                 timeout_err
);

   localparam int AW = SEG_BITS + 14;
   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [3:0] {
      IDLE, WR_SYNC, WR_ISSUE, WR_WAIT, WR_DONE,
      RD_ISSUE, RD_WAIT, RD_HOLD, IO_HOLD
   } state_t;

   state_t state, state_nxt;

   logic [3:0][SEG_BITS-1:0] seg, seg_eff;
   logic                     mem_rd, mem_wr, io_hit, io_wr, io_rd, io_wr_q, seg_we;
   logic [AW-1:0]            addr_cur, addr_q;
   logic [7:0]               data_q, rd_byte, io_rdata;
   logic [CW-1:0]            cnt;
   logic                     ld_addr, ld_data, fire_wr, cnt_clr, cnt_inc;
   logic                     rd_ok, rd_tmo, tmo, io_go, drv_off;

   assign mem_rd = !bus_mreq_n && !bus_rd_n && !bus_sltsl_n && bus_rfsh_n;
   assign mem_wr = !bus_mreq_n && !bus_wr_n && !bus_sltsl_n && bus_rfsh_n;
   assign io_hit = !bus_iorq_n && (bus_addr[7:2] == IO_BASE[7:2]);
   assign io_wr  = io_hit && !bus_wr_n;
   assign io_rd  = READBACK && io_hit && !bus_rd_n;
   assign seg_we = io_wr && !io_wr_q;

   // Segment view with this cycle's port write already applied, so a memory
   // cycle decoded in the same clock translates through the new value.
   always_comb begin
      seg_eff = seg;
      if (seg_we) seg_eff[bus_addr[1:0]] = bus_din[SEG_BITS-1:0];
   end

   assign addr_cur = {seg_eff[bus_addr[15:14]], bus_addr[13:0]};
   assign rd_byte  = addr_q[0] ? psram_dout[15:8] : psram_dout[7:0];

   // Port readback: unused high bits read as 1.
   always_comb begin
      io_rdata                 = 8'hFF;
      io_rdata[SEG_BITS-1:0]   = seg[bus_addr[1:0]];
   end

   assign psram_read = (state == RD_ISSUE);
   assign psram_addr = addr_q;
   assign psram_din  = {data_q, data_q};

   // Segment registers and mapper-port write edge detector.
   always_ff @(posedge clk_72m or negedge bus_reset_n) begin
      if (!bus_reset_n) begin
         io_wr_q <= 1'b0;
         for (int i = 0; i < 4; i++) seg[i] <= SEG_BITS'(3 - i);
      end else begin
         io_wr_q <= io_wr;
         if (seg_we) seg[bus_addr[1:0]] <= bus_din[SEG_BITS-1:0];
      end
   end

   // FSM state register.
   always_ff @(posedge clk_72m or negedge bus_reset_n) begin
      if (!bus_reset_n) state <= IDLE;
      else              state <= state_nxt;
   end

   // Next-state and per-state control strobes for the datapath.
   always_comb begin
      state_nxt = state;
      ld_addr   = 1'b0;
      ld_data   = 1'b0;
      fire_wr   = 1'b0;
      cnt_clr   = 1'b0;
      cnt_inc   = 1'b0;
      rd_ok     = 1'b0;
      rd_tmo    = 1'b0;
      tmo       = 1'b0;
      io_go     = 1'b0;
      drv_off   = 1'b0;
      case (state)
         IDLE: begin
            cnt_clr = 1'b1;
            if (mem_wr) begin
               ld_addr = 1'b1; ld_data = 1'b1; state_nxt = WR_SYNC;
            end else if (mem_rd) begin
               ld_addr = 1'b1; state_nxt = RD_ISSUE;
            end else if (io_rd) begin
               io_go = 1'b1; state_nxt = IO_HOLD;
            end
         end
         // Z80 write data is only valid late in the cycle: wait for a low
         // then high phase of the Z80 clock, resampling all the while.
         WR_SYNC: begin
            ld_addr = 1'b1; ld_data = 1'b1;
            if (!bus_clk_3m6) state_nxt = WR_ISSUE;
         end
         WR_ISSUE: begin
            ld_addr = 1'b1; ld_data = 1'b1;
            if (bus_clk_3m6) begin
               fire_wr = 1'b1; state_nxt = WR_WAIT;
            end
         end
         WR_WAIT: begin
            if (!psram_busy && !mem_wr) state_nxt = IDLE;
            else if (psram_busy) begin
               if (cnt == CW'(TIMEOUT)) begin
                  tmo = 1'b1; state_nxt = WR_DONE;
               end else cnt_inc = 1'b1;
            end
         end
         WR_DONE:  if (!mem_wr) state_nxt = IDLE;
         RD_ISSUE: state_nxt = RD_WAIT;
         RD_WAIT: begin
            if (!psram_busy) begin
               rd_ok = 1'b1; state_nxt = RD_HOLD;
            end else if (cnt == CW'(TIMEOUT)) begin
               rd_tmo = 1'b1; tmo = 1'b1; state_nxt = RD_HOLD;
            end else cnt_inc = 1'b1;
         end
         RD_HOLD, IO_HOLD: begin
            if (bus_rd_n) begin
               drv_off = 1'b1; state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath: latched request, write pulse, timeout counter, bus return.
   always_ff @(posedge clk_72m or negedge bus_reset_n) begin
      if (!bus_reset_n) begin
         addr_q      <= '0;
         data_q      <= '0;
         psram_write <= 1'b0;
         cnt         <= '0;
         bus_dout    <= 8'hFF;
         bus_drive   <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         if (ld_addr) addr_q <= addr_cur;
         if (ld_data) data_q <= bus_din;
         psram_write <= fire_wr;
         if (cnt_clr)      cnt <= '0;
         else if (cnt_inc) cnt <= cnt + CW'(1);
         if (tmo) timeout_err <= 1'b1;
         if (rd_ok) begin
            bus_dout <= rd_byte; bus_drive <= 1'b1;
         end else if (rd_tmo) begin
            bus_dout <= 8'hFF; bus_drive <= 1'b1;
         end else if (io_go) begin
            bus_dout <= io_rdata; bus_drive <= 1'b1;
         end else if (drv_off) begin
            bus_dout <= 8'hFF; bus_drive <= 1'b0;
         end
      end
   end

endmodule
